// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU block.
//   - ALU_* opcode encodings used by alu_core and by anything issuing ops
//   - state_t: result-register state (empty / holding an undelivered result)
//   - NUM_REQ: number of requesters sharing the ALU
package alu_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_DIV  = 3'b011;
    localparam logic [2:0] ALU_MOD  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_GT   = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two requesters / one consumer and alu_arbiter.
//   req0_*/req1_* : valid/ready operation ports (opcode, operands a and b)
//   rsp_*         : valid/ready result port (id, DW+1 bit result, div-by-zero)
//   master        : the issuing / consuming side
//   slave         : the arbiter side
interface alu_arbiter_if #(
    parameter int DW = 4
);
    logic          req0_valid;
    logic          req0_ready;
    logic [2:0]    req0_sel;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;

    logic          req1_valid;
    logic          req1_ready;
    logic [2:0]    req1_sel;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW:0]   rsp_out;
    logic          rsp_err;

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_err
    );

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_err
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 8-function ALU.
//   sel      : opcode (ALU_* in alu_pkg)
//   a, b     : DW-bit unsigned operands
//   result   : DW+1 bit result (carry / borrow / shifted-out bit in the MSB)
//   div_zero : divide or modulo with b == 0 (result forced to 0)
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [2:0]    sel,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW:0]   result,
    output logic          div_zero
);

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (sel)
            ALU_PASS: result = {1'b0, a};
            ALU_ADD:  result = {1'b0, a} + {1'b0, b};
            // Borrow propagates into the extra MSB, i.e. wraps mod 2^(DW+1).
            ALU_SUB:  result = {1'b0, a} - {1'b0, b};
            ALU_DIV: begin
                if (b == '0) div_zero = 1'b1;
                else         result   = {1'b0, a / b};
            end
            ALU_MOD: begin
                if (b == '0) div_zero = 1'b1;
                else         result   = {1'b0, a % b};
            end
            ALU_SHL:  result = {a, 1'b0};
            ALU_SHR:  result = {2'b00, a[DW-1:1]};
            ALU_GT:   result = {{DW{1'b0}}, (a > b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared alu_core, with a
// single-entry result register returned over a valid/ready response port.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : alu_arbiter_if slave modport (req0_*, req1_*, rsp_*)
// A new operation is accepted whenever the result register is empty or is
// being drained in the same cycle, giving one op per cycle under no
// backpressure.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic clk,
    input  logic rst,
    alu_arbiter_if.slave bus
);

    // Requester ports flattened into arrays so grant/mux logic is indexable.
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [2:0]         req_sel [NUM_REQ];
    logic [DW-1:0]      req_a   [NUM_REQ];
    logic [DW-1:0]      req_b   [NUM_REQ];

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign req_sel[0] = bus.req0_sel;
    assign req_sel[1] = bus.req1_sel;
    assign req_a[0]   = bus.req0_a;
    assign req_a[1]   = bus.req1_a;
    assign req_b[0]   = bus.req0_b;
    assign req_b[1]   = bus.req1_b;

    state_t      state_reg;
    logic        last_grant_reg;
    logic [DW:0] rsp_out_reg;
    logic        rsp_id_reg;
    logic        rsp_err_reg;

    logic        slot_avail;
    logic        grant_any;
    logic        grant_idx;
    logic [DW:0] alu_result;
    logic        alu_div_zero;

    // Drain-and-refill: a full register frees up in the same cycle it is taken.
    assign slot_avail = (state_reg == ST_EMPTY) || bus.rsp_ready;
    assign grant_any  = !rst && slot_avail && (|req_valid);

    // On a tie the requester not served last wins; otherwise the sole valid one.
    always_comb begin
        grant_idx = 1'b0;
        if (&req_valid) grant_idx = ~last_grant_reg;
        else            grant_idx = req_valid[1];
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && (grant_idx == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    alu_core #(
        .DW(DW)
    ) u_alu_core (
        .sel      (req_sel[grant_idx]),
        .a        (req_a[grant_idx]),
        .b        (req_b[grant_idx]),
        .result   (alu_result),
        .div_zero (alu_div_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_EMPTY;
            last_grant_reg <= 1'b1;
            rsp_out_reg    <= '0;
            rsp_id_reg     <= 1'b0;
            rsp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (grant_any) begin
                        rsp_out_reg    <= alu_result;
                        rsp_id_reg     <= grant_idx;
                        rsp_err_reg    <= alu_div_zero;
                        last_grant_reg <= grant_idx;
                        state_reg      <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (grant_any) begin
                        rsp_out_reg    <= alu_result;
                        rsp_id_reg     <= grant_idx;
                        rsp_err_reg    <= alu_div_zero;
                        last_grant_reg <= grant_idx;
                    end else if (bus.rsp_ready) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    assign bus.rsp_valid = (state_reg == ST_FULL);
    assign bus.rsp_out   = rsp_out_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and result buffer for the shared 8-function ALU. It accepts operations from two independent clients over valid/ready handshakes and grants the ALU round-robin. It registers each result with the winning requester's ID and returns it over a single valid/ready response port. The block sits between the instruction-issue logic and the ALU datapath, so one combinational ALU can serve two pipelines.

## Interface
- DW, 4, operand width; result width is DW+1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_sel  in  3  requester 0 opcode
- req0_a, req0_b  in  DW  requester 0 operands
- req1_valid, req1_ready, req1_sel, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes the result
- rsp_id  out  1  requester that issued the held result
- rsp_out  out  DW+1  held ALU result
- rsp_err  out  1  divide/modulo by zero on the held result

## Operation
- Opcodes:
  - 000: a
  - 001: a+b
  - 010: a-b, wraps mod 2^(DW+1)
  - 011: a/b
  - 100: a%b
  - 101: a<<1, carry kept in the MSB
  - 110: a>>1
  - 111: (a>b), zero-extended
- Opcode 011 or 100 with b==0: rsp_out=0, rsp_err=1. rsp_err=0 for every other case.
- FSM, 2 states:
  - EMPTY: result register is empty.
  - FULL: result register holds an undelivered result.
- Slot available: the state is EMPTY, or the state is FULL with rsp_ready=1 (drain and refill in the same cycle).
- Arbitration:
  - When a slot is available, grant one valid requester.
  - If both are valid, grant the one not granted last, using a 1-bit last_grant pointer.
  - The pointer updates only on an actual grant.
- reqN_ready is combinational and equals grant to N. It is never asserted for both requesters, never asserted when no slot is available, and it does not depend on reqN_valid for the granted index. A requester whose reqN_valid is low sees ready=0.
- On accept: the ALU result, rsp_id and rsp_err are registered, and the state becomes FULL.
- FULL with rsp_ready=1 and no accept: the state becomes EMPTY.
- FULL with rsp_ready=0: all outputs hold stable and both readies are 0.
- A requester that is not granted may hold valid indefinitely. Round-robin ordering guarantees it is granted within 2 accepts.

## Timing
- Reset values: rsp_valid=0, rsp_out=0, rsp_id=0, rsp_err=0, state EMPTY, last_grant=1 (requester 0 wins the first tie). Both readies are 0 while rst=1.
- Latency: an operation accepted at edge N shows rsp_valid=1 with its result after edge N.
- Throughput: 1 operation per cycle while rsp_ready stays high.
- Reset asserted mid-operation discards any held result with no response. Requests pending during reset are not accepted.
- The response port holds rsp_out, rsp_id and rsp_err stable while rsp_valid=1 and rsp_ready=0.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams ALU_PASS, ALU_ADD, ALU_SUB, ALU_DIV, ALU_MOD, ALU_SHL, ALU_SHR, ALU_GT
  - State enum {ST_EMPTY, ST_FULL}
- Sub-module `alu_core`: the combinational 8-function datapath plus the zero-divisor flag, parameterised by DW. It is instantiated once, fed by the grant mux.
- The arbiter, FSM and result register live in `alu_arbiter`.

## Test plan
- Reset then single op: req0 {sel=001, a=9, b=8} -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_out=17, rsp_id=0, rsp_err=0.
- Tie and fairness: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one response per cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles with both valid -> both readies 0 and the response is held stable; on release the next grant goes to the non-last requester.
- Zero divisor: req1 {sel=011, a=7, b=0} -> rsp_out=0, rsp_err=1, rsp_id=1. Then {sel=100, a=7, b=3} -> rsp_out=1, rsp_err=0.
- Width edges:
  - sub 2-5 -> rsp_out=5'b11101
  - shl 15 -> rsp_out=30
  - gt 3>9 -> rsp_out=0
- Reset mid-operation: assert rst while FULL with rsp_ready=0 -> next cycle rsp_valid=0; after rst drops, a tie grants requester 0.
